// File: rtl/tetris_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tetris_pkg
// Description : Shared state encodings, widths and gravity-period helper.
// Revision    : 1.0 - initial release
// ============================================================================
package tetris_pkg;

   localparam int c_state_w = 3;
   localparam int c_line_w  = 16;

   typedef enum logic [c_state_w-1:0] {
      ST_PRE = 3'd0,
      ST_DEL = 3'd1,
      ST_DRO = 3'd2,
      ST_LCK = 3'd3,
      ST_PAU = 3'd4,
      ST_END = 3'd5
   } state_t;

   // The level*step product is formed wide so large levels clamp to the floor
   // instead of wrapping below zero.
   function automatic logic [31:0] calc_period(input logic [31:0] lvl,
                                               input logic [31:0] base,
                                               input logic [31:0] step,
                                               input logic [31:0] min_p);
      logic [63:0] red;
      logic [31:0] diff;
      red  = {32'd0, lvl} * {32'd0, step};
      diff = min_p;
      if (red < {32'd0, base}) diff = base - red[31:0];
      return (diff < min_p) ? min_p : diff;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tetris_tick_timer.sv
`default_nettype none
// ============================================================================
// Module      : tetris_tick_timer
// Description : Enable/clear up-counter with a one-cycle terminal-count pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tetris_tick_timer (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_en,
   input  logic        i_clr,
   input  logic [31:0] i_tc,
   output logic        o_done
);

   logic [31:0] r_count;

   // A count already beyond the terminal value (period shrank) fires at once.
   assign o_done = i_en && !i_clr && (r_count >= i_tc);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_count <= '0;
      else if (i_clr)
         r_count <= '0;
      else if (i_en)
         r_count <= o_done ? 32'd0 : r_count + 32'd1;
   end

endmodule
`default_nettype wire

// File: rtl/tetris_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tetris_game_ctrl
// Description : Game-flow FSM with gravity/lock timing, level and line tracking.
// Revision    : 1.0 - initial release
// ============================================================================
module tetris_game_ctrl
   import tetris_pkg::*;
#(
   parameter int BASE_PERIOD     = 50_000_000,
   parameter int PERIOD_STEP     = 4_000_000,
   parameter int MIN_PERIOD      = 5_000_000,
   parameter int LOCK_CYCLES     = 25_000_000,
   parameter int LINES_PER_LEVEL = 10,
   parameter int MAX_LEVEL       = 9
)(
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic                           pause,
   input  logic                           del_done,
   input  logic [2:0]                     lines_cleared,
   input  logic                           touch,
   input  logic                           game_over,
   output logic [c_state_w-1:0]           state,
   output logic                           drop_tick,
   output logic                           lock,
   output logic [$clog2(MAX_LEVEL+1)-1:0] level,
   output logic [c_line_w-1:0]            line_count
);

   localparam int                  c_lvl_w   = $clog2(MAX_LEVEL + 1);
   localparam logic [c_lvl_w-1:0]  c_max_lvl = c_lvl_w'(MAX_LEVEL);
   localparam logic [15:0]         c_lpl     = 16'(LINES_PER_LEVEL);
   localparam logic [31:0]         c_lock_tc = 32'(LOCK_CYCLES - 1);

   state_t              r_state;
   state_t              w_next;
   state_t              r_origin;
   logic [31:0]         r_period;
   logic [c_lvl_w-1:0]  r_level;
   logic [c_lvl_w-1:0]  w_level_nxt;
   logic [15:0]         r_lines;
   logic [15:0]         w_lines_nxt;
   logic [15:0]         r_to_next;
   logic [15:0]         w_to_next_nxt;
   logic [16:0]         w_sum;
   logic                w_hold;
   logic                w_drop_en;
   logic                w_lock_en;
   logic                w_lock_clr;
   logic                w_game_clr;
   logic                w_add_lines;
   logic                w_store;
   logic                w_drop_done;
   logic                w_lock_done;

   // Timers advance only on cycles where the FSM stays in their state.
   assign w_hold      = !game_over && !start && !pause;
   assign w_drop_en   = (r_state == ST_DRO) && w_hold && !touch;
   assign w_lock_clr  = (r_state == ST_DRO) && w_hold && touch;
   assign w_lock_en   = (r_state == ST_LCK) && w_hold && touch;
   assign w_game_clr  = (r_state == ST_PRE) && start;
   assign w_add_lines = (r_state == ST_DEL) && del_done && !game_over && !start;
   assign w_store     = ((r_state == ST_DRO) || (r_state == ST_LCK)) &&
                        pause && !start && !game_over;

   tetris_tick_timer u_drop_timer (
      .clk    (clk),
      .rst    (rst),
      .i_en   (w_drop_en),
      .i_clr  (w_game_clr),
      .i_tc   (r_period - 32'd1),
      .o_done (w_drop_done)
   );

   tetris_tick_timer u_lock_timer (
      .clk    (clk),
      .rst    (rst),
      .i_en   (w_lock_en),
      .i_clr  (w_game_clr | w_lock_clr),
      .i_tc   (c_lock_tc),
      .o_done (w_lock_done)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_state <= ST_PRE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_PRE: if (start) w_next = ST_DEL;
         ST_DEL: begin
            if (game_over)     w_next = ST_END;
            else if (start)    w_next = ST_PRE;
            else if (del_done) w_next = ST_DRO;
         end
         ST_DRO: begin
            if (game_over)     w_next = ST_END;
            else if (start)    w_next = ST_PRE;
            else if (pause)    w_next = ST_PAU;
            else if (touch)    w_next = ST_LCK;
         end
         ST_LCK: begin
            if (game_over)        w_next = ST_END;
            else if (start)       w_next = ST_PRE;
            else if (pause)       w_next = ST_PAU;
            else if (!touch)      w_next = ST_DRO;
            else if (w_lock_done) w_next = ST_DEL;
         end
         ST_PAU: begin
            if (game_over)     w_next = ST_END;
            else if (start)    w_next = ST_PRE;
            else if (pause)    w_next = r_origin;
         end
         ST_END: if (start) w_next = ST_PRE;
         default: w_next = ST_PRE;
      endcase
   end

   // One pass per cleared line so a multi-line clear can cross several levels.
   always_comb begin
      w_sum         = {1'b0, r_lines} + {14'd0, lines_cleared};
      w_lines_nxt   = w_sum[16] ? 16'hFFFF : w_sum[15:0];
      w_level_nxt   = r_level;
      w_to_next_nxt = r_to_next;
      for (int i = 0; i < 7; i++) begin
         if (3'(i) < lines_cleared) begin
            if (w_to_next_nxt <= 16'd1) begin
               w_to_next_nxt = c_lpl;
               if (w_level_nxt != c_max_lvl)
                  w_level_nxt = w_level_nxt + c_lvl_w'(1);
            end else begin
               w_to_next_nxt = w_to_next_nxt - 16'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_lines   <= '0;
         r_level   <= '0;
         r_to_next <= c_lpl;
         r_origin  <= ST_DRO;
         r_period  <= calc_period(32'd0, 32'(BASE_PERIOD), 32'(PERIOD_STEP),
                                  32'(MIN_PERIOD));
      end else begin
         r_period <= calc_period(32'(r_level), 32'(BASE_PERIOD),
                                 32'(PERIOD_STEP), 32'(MIN_PERIOD));
         if (w_game_clr) begin
            r_lines   <= '0;
            r_level   <= '0;
            r_to_next <= c_lpl;
         end else if (w_add_lines) begin
            r_lines   <= w_lines_nxt;
            r_level   <= w_level_nxt;
            r_to_next <= w_to_next_nxt;
         end
         if (w_store)
            r_origin <= r_state;
      end
   end

   assign state      = r_state;
   assign drop_tick  = w_drop_done;
   assign lock       = w_lock_done;
   assign level      = r_level;
   assign line_count = r_lines;

endmodule
`default_nettype wire

// File: doc/tetris_game_ctrl.md
TETRIS_GAME_CTRL -- requirements
Module: tetris_game_ctrl

Interface
REQ-001 Parameter BASE_PERIOD, default 50_000_000: gravity period in clk cycles at level 0.
REQ-002 Parameter PERIOD_STEP, default 4_000_000: period reduction per level.
REQ-003 Parameter MIN_PERIOD, default 5_000_000: floor on gravity period.
REQ-004 Parameter LOCK_CYCLES, default 25_000_000: cycles a touching piece waits before locking.
REQ-005 Parameter LINES_PER_LEVEL, default 10: cleared lines per level increment.
REQ-006 Parameter MAX_LEVEL, default 9: saturation level; LVL_W = $clog2(MAX_LEVEL+1).
REQ-007 clk  in  1  single clock, all logic on rising edge.
REQ-008 rst  in  1  asynchronous, active-low reset.
REQ-009 start  in  1  single-cycle pulse: begin game from PRE/END, restart from any other state.
REQ-010 pause  in  1  single-cycle pulse: toggle pause.
REQ-011 del_done  in  1  single-cycle pulse: line-delete/spawn phase finished.
REQ-012 lines_cleared  in  3  lines removed (0..4), valid only with del_done.
REQ-013 touch  in  1  level: active piece rests on stack/floor.
REQ-014 game_over  in  1  level: spawn collision detected.
REQ-015 state  out  3  current state encoding.
REQ-016 drop_tick  out  1  one-cycle pulse: move piece down one row.
REQ-017 lock  out  1  one-cycle pulse: commit piece to board.
REQ-018 level  out  LVL_W  current level.
REQ-019 line_count  out  16  total lines cleared this game.

Function
REQ-020 States SHALL be PRE=0, DEL=1, DRO=2, LCK=3, PAU=4, END=5; codes 6,7 SHALL go to PRE next cycle.
REQ-021 Transition priority SHALL be: game_over (to END, from DEL/DRO/LCK/PAU) > start > pause > state-local condition.
REQ-022 PRE: start -> DEL; line_count, level, both timers cleared on that transition.
REQ-023 DEL: del_done -> DRO; same cycle line_count += lines_cleared, saturating at 16'hFFFF.
REQ-024 DRO: drop timer counts up; at count == period-1 drop_tick pulses one cycle and timer reloads 0; touch -> LCK with lock timer cleared.
REQ-025 LCK: lock timer counts; touch low -> DRO with drop timer preserved; count == LOCK_CYCLES-1 -> lock pulse one cycle, next state DEL; no drop_tick in LCK.
REQ-026 pause in DRO or LCK -> PAU, origin stored; pause in PAU -> stored origin; pause ignored in PRE, DEL, END.
REQ-027 PAU: both timers frozen, no drop_tick or lock.
REQ-028 start in DEL/DRO/LCK/PAU/END -> PRE; start in PRE -> DEL.
REQ-029 END: only start leaves (to PRE); outputs level/line_count hold final values.
REQ-030 period = max(MIN_PERIOD, BASE_PERIOD - level*PERIOD_STEP), computed without underflow in 32-bit arithmetic, registered and updated one cycle after level changes.
REQ-031 Level SHALL increment by one each time line_count crosses a LINES_PER_LEVEL multiple (tracked by a lines-to-next counter, no divider); a 4-line clear crossing two boundaries SHALL increment twice; saturates at MAX_LEVEL.
REQ-032 drop_tick and lock SHALL never assert in the same cycle.

Reset
REQ-033 rst low SHALL asynchronously force state=PRE, drop_tick=0, lock=0, level=0, line_count=0, timers=0, stored pause origin=DRO.
REQ-034 Reset assertion mid-game SHALL abandon all progress; release SHALL resume at PRE with no output pulse.

Structure
REQ-035 State encodings and the 3-bit state width SHALL live in shared package tetris_pkg.
REQ-036 Drop and lock timers SHALL each be an instance of sub-module tetris_tick_timer (enable, clear, terminal-count input, one-cycle done pulse).

Verification (BASE_PERIOD=8, PERIOD_STEP=2, MIN_PERIOD=2, LOCK_CYCLES=4, LINES_PER_LEVEL=4, MAX_LEVEL=3)
REQ-037 start, del_done(lines=0), hold touch=0 for 24 cycles -> drop_tick every 8 cycles, 3 pulses, state=DRO.
REQ-038 In DRO raise touch for 4 cycles -> state=LCK, lock pulses on 4th LCK cycle, state=DEL next; touch dropped after 2 cycles instead -> back to DRO, no lock.
REQ-039 del_done with lines_cleared=4 twice -> line_count=8, level=2, drop_tick period 4; further 8 lines -> level=3, period 2 (floor).
REQ-040 pause in DRO after 5 timer cycles, wait 20, pause again -> state PAU then DRO, first drop_tick exactly 3 cycles after resume.
REQ-041 game_over in PAU with simultaneous start -> END; then start -> PRE; start -> DEL with line_count=0, level=0.
REQ-042 rst low mid-LCK, asynchronous to clk -> outputs zero, state=PRE immediately; no lock pulse after release.
